// File: rtl/conv3_mem_pkg.sv
// Shared memory map and sequencer state encoding for the conv3 accelerator.
// Used by the job sequencer, the accelerator and any bus model.
package conv3_mem_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, START, POLL, DRAIN} state_t;

   // Loaded words per job: 2 weight words plus 9 data words per group of 8 kernels.
   function automatic int ram_depth(input int kernel_num);
      return 2 + 9 * (kernel_num / 8);
   endfunction

   // Control registers occupy the top three addresses of the window.
   function automatic int clear_addr(input int aw);
      return (1 << aw) - 3;
   endfunction

   function automatic int start_addr(input int aw);
      return (1 << aw) - 2;
   endfunction

   function automatic int done_addr(input int aw);
      return (1 << aw) - 1;
   endfunction

endpackage

// File: rtl/conv3_job_sequencer.sv
// Bus initiator running one conv3 job: optional clear, load, start, poll done,
// then drain KERNEL_NUM results through a one-entry output register.
module conv3_job_sequencer
   import conv3_mem_pkg::*;
#(
   parameter int PRECISION_WIDTH  = 4,
   parameter int VALID_ADDR_WIDTH = 14,
   parameter int DATA_WIDTH       = 32,
   parameter int KERNEL_NUM       = 112,
   parameter int POLL_TIMEOUT     = 64,
   localparam int RES_W           = 2 * PRECISION_WIDTH + 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_job_valid,
   output logic                        o_job_ready,
   input  logic                        i_job_clear,
   input  logic                        i_wr_valid,
   output logic                        o_wr_ready,
   input  logic [DATA_WIDTH-1:0]       i_wr_data,
   output logic                        o_res_valid,
   input  logic                        i_res_ready,
   output logic [RES_W-1:0]            o_res_data,
   output logic                        o_res_last,
   output logic                        o_busy,
   output logic                        o_timeout,
   output logic                        o_mem_we,
   output logic [VALID_ADDR_WIDTH-1:0] o_mem_waddr,
   output logic [DATA_WIDTH-1:0]       o_mem_wdata,
   output logic                        o_mem_re,
   output logic [VALID_ADDR_WIDTH-1:0] o_mem_raddr,
   input  logic [DATA_WIDTH-1:0]       i_mem_rdata
);

   localparam int RAM_DEPTH = ram_depth(KERNEL_NUM);
   localparam int LW        = $clog2(RAM_DEPTH);
   localparam int KW        = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
   localparam int PW        = $clog2(POLL_TIMEOUT + 1);

   typedef logic [VALID_ADDR_WIDTH-1:0] addr_t;

   localparam addr_t A_CLEAR = addr_t'(clear_addr(VALID_ADDR_WIDTH));
   localparam addr_t A_START = addr_t'(start_addr(VALID_ADDR_WIDTH));
   localparam addr_t A_DONE  = addr_t'(done_addr(VALID_ADDR_WIDTH));
   localparam addr_t A_RES0  = addr_t'(RAM_DEPTH);

   state_t           state;
   logic [LW-1:0]    ld_cnt;
   logic [KW-1:0]    rd_cnt;
   logic [PW-1:0]    poll_cnt;
   logic             re_q;
   logic             res_valid;
   logic             res_last;
   logic [RES_W-1:0] res_data;
   logic             res_take;
   logic             rd_fire;
   logic             unused_rdata;

   assign o_job_ready = (state == IDLE);
   assign o_busy      = (state != IDLE);
   assign o_wr_ready  = (state == LOAD);
   assign o_res_valid = res_valid;
   assign o_res_data  = res_data;
   assign o_res_last  = res_last;

   assign res_take = res_valid && i_res_ready;
   // The read strobe is the registered request gated by back-pressure, so a
   // stalled result register suppresses the read in the very same cycle.
   assign rd_fire  = re_q && (!res_valid || i_res_ready);
   assign o_mem_re = rd_fire;

   assign unused_rdata = ^i_mem_rdata[DATA_WIDTH-1:RES_W];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         ld_cnt      <= '0;
         rd_cnt      <= '0;
         poll_cnt    <= '0;
         re_q        <= 1'b0;
         res_valid   <= 1'b0;
         res_last    <= 1'b0;
         res_data    <= '0;
         o_timeout   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_waddr <= '0;
         o_mem_wdata <= '0;
         o_mem_raddr <= '0;
      end else begin
         o_mem_we <= 1'b0;
         if (res_take) res_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (i_job_valid) begin
                  o_timeout <= 1'b0;
                  ld_cnt    <= '0;
                  state     <= i_job_clear ? CLEAR : LOAD;
               end
            end

            CLEAR: begin
               o_mem_we    <= 1'b1;
               o_mem_waddr <= A_CLEAR;
               o_mem_wdata <= DATA_WIDTH'(1);
               state       <= LOAD;
            end

            LOAD: begin
               if (i_wr_valid) begin
                  o_mem_we    <= 1'b1;
                  o_mem_waddr <= addr_t'(ld_cnt);
                  o_mem_wdata <= i_wr_data;
                  if (ld_cnt == LW'(RAM_DEPTH - 1)) begin
                     ld_cnt <= '0;
                     state  <= START;
                  end else begin
                     ld_cnt <= ld_cnt + 1'b1;
                  end
               end
            end

            START: begin
               o_mem_we    <= 1'b1;
               o_mem_waddr <= A_START;
               o_mem_wdata <= '0;
               poll_cnt    <= '0;
               state       <= POLL;
            end

            POLL: begin
               // First POLL cycle carries the START write; reads begin after it.
               if (!re_q) begin
                  re_q        <= 1'b1;
                  o_mem_raddr <= A_DONE;
               end else if (i_mem_rdata[0]) begin
                  o_mem_raddr <= A_RES0;
                  rd_cnt      <= '0;
                  state       <= DRAIN;
               end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
                  re_q      <= 1'b0;
                  o_timeout <= 1'b1;
                  state     <= IDLE;
               end else begin
                  poll_cnt <= poll_cnt + 1'b1;
               end
            end

            DRAIN: begin
               if (rd_fire) begin
                  res_valid <= 1'b1;
                  res_data  <= i_mem_rdata[RES_W-1:0];
                  res_last  <= (rd_cnt == KW'(KERNEL_NUM - 1));
                  if (rd_cnt == KW'(KERNEL_NUM - 1)) begin
                     re_q <= 1'b0;
                  end else begin
                     rd_cnt      <= rd_cnt + 1'b1;
                     o_mem_raddr <= o_mem_raddr + 1'b1;
                  end
               end
               if (res_take && res_last) begin
                  res_last <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv3_job_sequencer.sv
// Directed bench for conv3_job_sequencer with a small accelerator bus model.
module tb_conv3_job_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid, job_ready, job_clear;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        res_valid, res_ready, res_last;
   logic [11:0] res_data;
   logic        busy, timeout;
   logic        mem_we, mem_re;
   logic [13:0] mem_waddr, mem_raddr;
   logic [31:0] mem_wdata, mem_rdata;

   int tests = 0;
   int fails = 0;

   conv3_job_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_job_valid(job_valid), .o_job_ready(job_ready), .i_job_clear(job_clear),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
      .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
      .o_res_last(res_last), .o_busy(busy), .o_timeout(timeout),
      .o_mem_we(mem_we), .o_mem_waddr(mem_waddr), .o_mem_wdata(mem_wdata),
      .o_mem_re(mem_re), .o_mem_raddr(mem_raddr), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Accelerator model: done rises 5 cycles after START when enabled, cleared by its read.
   logic [31:0] res_mem [0:111];
   logic        done;
   int          cd;
   bit          done_en;

   always @(posedge clk) begin
      if (!rst_n) begin
         done <= 1'b0;
         cd   <= 0;
      end else begin
         if (mem_we && mem_waddr == 14'd16382) cd <= 5;
         else if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1 && done_en) done <= 1'b1;
         end
         if (mem_re && mem_raddr == 14'd16383 && done) done <= 1'b0;
      end
   end

   always_comb begin
      mem_rdata = 32'hDEAD_BEE0;
      if (mem_raddr == 14'd16383) mem_rdata = {31'h7FFF_0000, done};
      else if (mem_raddr >= 14'd128 && mem_raddr < 14'd240)
         mem_rdata = res_mem[int'(mem_raddr) - 128];
   end

   // Bus / result logs, sampled mid-cycle.
   int          wa_q[$];
   logic [31:0] wd_q[$];
   int          ra_q[$];
   logic [11:0] rd_q[$];
   bit          rl_q[$];
   int          poll_reads, resv_seen, stall_err, both_err;
   bit          prev_stall;
   logic [11:0] prev_data;
   logic        prev_last;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we && mem_re) both_err++;
         if (mem_we) begin
            wa_q.push_back(int'(mem_waddr));
            wd_q.push_back(mem_wdata);
         end
         if (mem_re) begin
            if (mem_raddr == 14'd16383) poll_reads++;
            else ra_q.push_back(int'(mem_raddr));
         end
         if (res_valid) resv_seen++;
         if (prev_stall && (!res_valid || res_data !== prev_data || res_last !== prev_last))
            stall_err++;
         prev_stall = res_valid && !res_ready;
         prev_data  = res_data;
         prev_last  = res_last;
         if (res_valid && res_ready) begin
            rd_q.push_back(res_data);
            rl_q.push_back(res_last);
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic clear_logs();
      wa_q.delete(); wd_q.delete(); ra_q.delete(); rd_q.delete(); rl_q.delete();
      poll_reads = 0; resv_seen = 0; stall_err = 0; both_err = 0;
   endtask

   task automatic start_job(input bit clr);
      bit ok = 0;
      job_valid = 1'b1;
      job_clear = clr;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (job_ready) ok = 1;
         @(posedge clk); #1;
      end
      job_valid = 1'b0;
      job_clear = 1'b0;
      if (!ok) begin
         tests++; fails++;
         $display("FAIL start_job: job_ready never seen, required 1");
      end
   endtask

   // mode 0: word k = k; mode 1: all ones data, weights 0x11111111.
   task automatic feed(input int mode, input bit gap);
      int bad = 0;
      for (int k = 0; k < 128; k++) begin
         bit ok = 0;
         wr_valid = 1'b1;
         wr_data  = (mode == 0) ? 32'(k) : ((k >= 126) ? 32'h1111_1111 : 32'hFFFF_FFFF);
         for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (wr_ready) ok = 1;
            @(posedge clk); #1;
         end
         wr_valid = 1'b0;
         if (!ok) bad++;
         if (gap) begin
            @(posedge clk); #1;
         end
      end
      if (bad != 0) begin
         tests++; fails++;
         $display("FAIL feed: %0d words not accepted, required 0", bad);
      end
   endtask

   task automatic wait_idle(input bit toggle);
      bit ok = 0;
      for (int c = 0; c < 2000 && !ok; c++) begin
         res_ready = toggle ? (c % 2 == 0) : 1'b1;
         @(negedge clk);
         if (!busy) ok = 1;
         @(posedge clk); #1;
      end
      res_ready = 1'b0;
      if (!ok) begin
         tests++; fails++;
         $display("FAIL wait_idle: still busy after budget, required idle");
      end
   endtask

   task automatic check_results(input string name, input int base, input int mul);
      int bad = 0, lasts = 0;
      tests++;
      if (rd_q.size() !== 112) begin
         fails++;
         $display("FAIL %s count: got %0d results, required 112", name, rd_q.size());
      end else begin
         for (int k = 0; k < 112; k++) begin
            if (rd_q[k] !== 12'(base + mul * k)) bad++;
            if (rl_q[k]) lasts++;
         end
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL %s data: %0d wrong results, required 0", name, bad);
         end
         tests++;
         if (lasts != 1 || rl_q[111] !== 1'b1) begin
            fails++;
            $display("FAIL %s last: %0d last flags, on k=111 %0b, required 1 and 1", name, lasts, rl_q[111]);
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      tests++;
      if (job_ready !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0 || res_valid !== 1'b0 ||
          timeout !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || res_last !== 1'b0 ||
          res_data !== 12'd0 || mem_waddr !== 14'd0 || mem_raddr !== 14'd0 || mem_wdata !== 32'd0) begin
         fails++;
         $display("FAIL %s: rdy=%0b busy=%0b wrr=%0b rv=%0b to=%0b we=%0b re=%0b, required 1,0,0,0,0,0,0 and zero buses",
                  name, job_ready, busy, wr_ready, res_valid, timeout, mem_we, mem_re);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; job_valid = 0; job_clear = 0; wr_valid = 0; wr_data = 0; res_ready = 0;
      done_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      #1; @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_logs();
   endtask

   task automatic test_clear_load();
      int bad = 0;
      clear_logs();
      done_en = 1'b1;
      for (int k = 0; k < 112; k++) res_mem[k] = 32'(k);
      start_job(1'b1);
      feed(0, 1'b0);
      wait_idle(1'b0);
      tests++;
      if (wa_q.size() !== 130) begin
         fails++;
         $display("FAIL clear_load writes: got %0d, required 130", wa_q.size());
      end else begin
         tests++;
         if (wa_q[0] !== 16381 || wd_q[0] !== 32'd1) begin
            fails++;
            $display("FAIL clear_load clear: addr %0d data %0d, required 16381 1", wa_q[0], wd_q[0]);
         end
         for (int k = 0; k < 128; k++)
            if (wa_q[k+1] !== k || wd_q[k+1] !== 32'(k)) bad++;
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL clear_load words: %0d wrong, required 0", bad);
         end
         tests++;
         if (wa_q[129] !== 16382) begin
            fails++;
            $display("FAIL clear_load start: addr %0d, required 16382", wa_q[129]);
         end
      end
      check_results("clear_load", 0, 1);
   endtask

   task automatic test_full_job();
      int bad = 0;
      clear_logs();
      done_en = 1'b1;
      for (int k = 0; k < 112; k++) res_mem[k] = 32'hABCD_E009;
      start_job(1'b0);
      feed(1, 1'b0);
      wait_idle(1'b0);
      tests++;
      if (wa_q.size() !== 129 || wa_q[0] !== 0 || wd_q[127] !== 32'h1111_1111 || wa_q[128] !== 16382) begin
         fails++;
         $display("FAIL full_job writes: n=%0d first=%0d w127=%h last=%0d, required 129 0 11111111 16382",
                  wa_q.size(), wa_q[0], wd_q[127], wa_q[128]);
      end
      tests++;
      if (ra_q.size() !== 112) begin
         fails++;
         $display("FAIL full_job reads: got %0d, required 112", ra_q.size());
      end else begin
         for (int k = 0; k < 112; k++) if (ra_q[k] !== 128 + k) bad++;
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL full_job raddr: %0d out of order, required 0", bad);
         end
      end
      check_results("full_job", 9, 0);
   endtask

   task automatic test_backpressure();
      clear_logs();
      done_en = 1'b1;
      for (int k = 0; k < 112; k++) res_mem[k] = 32'hF000_0000 | 32'(3 * k + 1);
      start_job(1'b0);
      feed(0, 1'b0);
      wait_idle(1'b1);
      check_results("backpressure", 1, 3);
      tests++;
      if (stall_err !== 0 || ra_q.size() !== 112) begin
         fails++;
         $display("FAIL backpressure stall: %0d unstable cycles, %0d reads, required 0 and 112",
                  stall_err, ra_q.size());
      end
   endtask

   task automatic test_timeout();
      clear_logs();
      done_en = 1'b0;
      start_job(1'b0);
      feed(0, 1'b0);
      wait_idle(1'b0);
      @(negedge clk);
      tests++;
      if (timeout !== 1'b1 || job_ready !== 1'b1) begin
         fails++;
         $display("FAIL timeout flag: to=%0b ready=%0b, required 1 1", timeout, job_ready);
      end
      tests++;
      if (poll_reads !== 64) begin
         fails++;
         $display("FAIL timeout polls: got %0d, required 64", poll_reads);
      end
      tests++;
      if (resv_seen !== 0 || rd_q.size() !== 0) begin
         fails++;
         $display("FAIL timeout results: %0d valid cycles, required 0", resv_seen);
      end
      @(posedge clk); #1;
      done_en = 1'b1;
   endtask

   task automatic test_wr_gaps();
      int bad = 0;
      clear_logs();
      done_en = 1'b1;
      for (int k = 0; k < 112; k++) res_mem[k] = 32'(k + 7);
      start_job(1'b0);
      @(negedge clk);
      tests++;
      if (timeout !== 1'b0) begin
         fails++;
         $display("FAIL gaps timeout clear: got %0b, required 0", timeout);
      end
      @(posedge clk); #1;
      feed(0, 1'b1);
      wait_idle(1'b0);
      tests++;
      if (wa_q.size() !== 129) begin
         fails++;
         $display("FAIL gaps writes: got %0d, required 129", wa_q.size());
      end else begin
         for (int k = 0; k < 128; k++) if (wa_q[k] !== k || wd_q[k] !== 32'(k)) bad++;
         tests++;
         if (bad != 0 || wa_q[128] !== 16382) begin
            fails++;
            $display("FAIL gaps order: %0d wrong, start addr %0d, required 0 16382", bad, wa_q[128]);
         end
      end
      check_results("gaps", 7, 1);
   endtask

   task automatic test_reset_in_drain();
      bit ok = 0;
      clear_logs();
      done_en = 1'b1;
      for (int k = 0; k < 112; k++) res_mem[k] = 32'(2 * k);
      start_job(1'b0);
      feed(0, 1'b0);
      res_ready = 1'b1;
      for (int c = 0; c < 500 && !ok; c++) begin
         @(negedge clk);
         if (rd_q.size() >= 50) ok = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL reset_drain reach: %0d results, required 50", rd_q.size());
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      res_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_drain outputs");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_logs();
      for (int k = 0; k < 112; k++) res_mem[k] = 32'(5 * k + 2);
      start_job(1'b1);
      feed(0, 1'b0);
      wait_idle(1'b0);
      tests++;
      if (wa_q.size() !== 130 || wa_q[0] !== 16381 || wa_q[1] !== 0) begin
         fails++;
         $display("FAIL reset_drain rerun writes: n=%0d a0=%0d a1=%0d, required 130 16381 0",
                  wa_q.size(), wa_q[0], wa_q[1]);
      end
      check_results("reset_drain rerun", 2, 5);
      tests++;
      if (both_err !== 0) begin
         fails++;
         $display("FAIL we_re overlap: %0d cycles, required 0", both_err);
      end
   endtask

   initial begin
      test_reset();
      test_clear_load();
      test_full_job();
      test_backpressure();
      test_timeout();
      test_wr_gaps();
      test_reset_in_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
